alt_vipvfr121_common_pack_data: RTL

ALT_VIPVFR121_COMMON_PACK_DATA -- requirements
Module: alt_vipvfr121_common_pack_data

---
 rtl/alt_vipvfr121_common_pkg.sv | 18 +
 rtl/alt_vipvfr121_common_pack_data.sv | 98 +++++++++
 2 files changed

// File: rtl/alt_vipvfr121_common_pkg.sv
// Shared helpers for the VIP frame-reader packing blocks: width arithmetic
// and parameter legality.
package alt_vipvfr121_common_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit widths_legal(input int unsigned width_in, input int unsigned width_out);
        return (width_in > 0) && (width_out >= width_in);
    endfunction

endpackage

// File: rtl/alt_vipvfr121_common_pack_data.sv
// Packs a stream of user pixels LSB-first into wide memory words, letting
// pixels straddle word boundaries; flush emits a zero-padded partial word.
module alt_vipvfr121_common_pack_data
    import alt_vipvfr121_common_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_IN  = 24,
    parameter int unsigned DATA_WIDTH_OUT = 128
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH_IN-1:0]  data_in,
    input  logic                      write_in,
    output logic                      stall_upstream,
    output logic [DATA_WIDTH_OUT-1:0] data_out,
    output logic                      write,
    input  logic                      stall_out,
    input  logic                      flush
);

    localparam int unsigned ACC_W = DATA_WIDTH_IN + DATA_WIDTH_OUT - 1;
    localparam int unsigned FW    = clog2(DATA_WIDTH_IN + DATA_WIDTH_OUT);
    localparam logic [FW-1:0] IN_F  = FW'(DATA_WIDTH_IN);
    localparam logic [FW-1:0] OUT_F = FW'(DATA_WIDTH_OUT);

    if (!widths_legal(DATA_WIDTH_IN, DATA_WIDTH_OUT)) begin : g_illegal_widths
        $error("DATA_WIDTH_OUT must be >= DATA_WIDTH_IN");
    end

    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [FW-1:0]             fill_q, fill_d;
    logic                      flush_pending_q, flush_pending_d;
    logic                      stall_q, stall_d;
    logic                      write_q, write_d;
    logic [DATA_WIDTH_OUT-1:0] dout_q, dout_d;
    logic [DATA_WIDTH_OUT-1:0] keep_mask;
    logic                      accept;

    // An accept only happens when fill < OUT and no flush is pending, so it
    // never coincides with an emission and can append to the unshifted state.
    always_comb begin
        acc_d           = acc_q;
        fill_d          = fill_q;
        flush_pending_d = flush_pending_q;
        dout_d          = dout_q;
        write_d         = 1'b0;
        accept          = write_in && !stall_q;
        keep_mask       = ~({DATA_WIDTH_OUT{1'b1}} << fill_q);

        if (!stall_out && (fill_q >= OUT_F)) begin
            dout_d  = acc_q[DATA_WIDTH_OUT-1:0];
            write_d = 1'b1;
            acc_d   = acc_q >> DATA_WIDTH_OUT;
            fill_d  = fill_q - OUT_F;
        end else if (flush_pending_q && (fill_q == '0)) begin
            flush_pending_d = 1'b0;
        end else if (flush_pending_q && !stall_out) begin
            dout_d          = acc_q[DATA_WIDTH_OUT-1:0] & keep_mask;
            write_d         = 1'b1;
            acc_d           = '0;
            fill_d          = '0;
            flush_pending_d = 1'b0;
        end

        if (accept) begin
            acc_d  = acc_d | (ACC_W'(data_in) << fill_d);
            fill_d = fill_d + IN_F;
        end

        if (flush && !flush_pending_q) begin
            flush_pending_d = 1'b1;
        end

        stall_d = (fill_d >= OUT_F) || flush_pending_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q           <= '0;
            fill_q          <= '0;
            flush_pending_q <= 1'b0;
            stall_q         <= 1'b0;
            write_q         <= 1'b0;
            dout_q          <= '0;
        end else begin
            acc_q           <= acc_d;
            fill_q          <= fill_d;
            flush_pending_q <= flush_pending_d;
            stall_q         <= stall_d;
            write_q         <= write_d;
            dout_q          <= dout_d;
        end
    end

    assign stall_upstream = stall_q;
    assign write          = write_q;
    assign data_out       = dout_q;

endmodule
